// File: rtl/alu_mc_pkg.sv
// alu_mc shared types: op codes, FSM states, op-range helpers.
// ALU_MC_DIV_EN adds the DIV state; otherwise divide ops finish in one cycle.
package alu_mc_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_SLT   = 4'd4,
    OP_SLTU  = 4'd5,
    OP_XOR   = 4'd6,
    OP_SLL   = 4'd7,
    OP_SRL   = 4'd8,
    OP_SRA   = 4'd9,
    OP_MUL   = 4'd10,
    OP_MULHU = 4'd11,
    OP_DIV   = 4'd12,
    OP_DIVU  = 4'd13,
    OP_REM   = 4'd14,
    OP_REMU  = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
`ifdef ALU_MC_DIV_EN
    ST_DIV  = 2'd2,
`endif
    ST_DONE = 2'd3
  } alu_state_e;

  localparam int unsigned OP_SC_LAST   = 9;
  localparam int unsigned OP_MUL_FIRST = 10;
  localparam int unsigned OP_MUL_LAST  = 11;
  localparam int unsigned OP_DIV_FIRST = 12;
  localparam int unsigned OP_DIV_LAST  = 15;

  function automatic logic is_mul_op(input logic [3:0] op);
    return (32'(op) >= OP_MUL_FIRST) && (32'(op) <= OP_MUL_LAST);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (32'(op) >= OP_DIV_FIRST) && (32'(op) <= OP_DIV_LAST);
  endfunction

endpackage

// File: rtl/alu_mc_if.sv
// alu_mc operand/result handshake bundle.
interface alu_mc_if #(parameter int unsigned XLEN = 32);
  logic            valid_i;
  logic            ready_o;
  logic [3:0]      ALUCtrl_i;
  logic [XLEN-1:0] data1_i;
  logic [XLEN-1:0] data2_i;
  logic            valid_o;
  logic            ready_i;
  logic [XLEN-1:0] data_o;
  logic            zero_o;

  modport master (
    output valid_i, ALUCtrl_i, data1_i, data2_i, ready_i,
    input  ready_o, valid_o, data_o, zero_o
  );

  modport slave (
    input  valid_i, ALUCtrl_i, data1_i, data2_i, ready_i,
    output ready_o, valid_o, data_o, zero_o
  );
endinterface

// File: rtl/alu_mc_iter.sv
// Shared hi/lo shift register for iterative multiply and restoring divide.
// Outputs o_hi_c/o_lo_c are the values after the current iteration, so the
// caller can capture the final result on the last-iteration edge.
// ALU_MC_DIV_EN builds the divide step; without it only multiply exists.
module alu_mc_iter
  import alu_mc_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            i_start,
  input  logic            i_mode_div,
  input  logic [XLEN-1:0] i_op_a,
  input  logic [XLEN-1:0] i_op_b,
  output logic            o_done_c,
  output logic [XLEN-1:0] o_hi_c,
  output logic [XLEN-1:0] o_lo_c
);
  localparam int unsigned SHW = $clog2(XLEN);
  localparam int unsigned CW  = SHW + 1;

  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_m;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;
  logic [XLEN:0]   w_sum;
  logic [XLEN-1:0] w_mul_hi;
  logic [XLEN-1:0] w_mul_lo;
  logic [XLEN-1:0] w_load_lo;
  logic [XLEN-1:0] w_load_m;

  // Radix-2 shift-add step: conditionally add multiplicand, shift pair right
  always_comb begin
    w_sum    = r_lo[0] ? ({1'b0, r_hi} + {1'b0, r_m}) : {1'b0, r_hi};
    w_mul_hi = w_sum[XLEN:1];
    w_mul_lo = {w_sum[0], r_lo[XLEN-1:1]};
  end

`ifdef ALU_MC_DIV_EN
  logic            r_mode_div;
  logic [XLEN:0]   w_shift;
  logic [XLEN-1:0] w_diff;
  logic            w_qbit;
  logic [XLEN-1:0] w_div_hi;
  logic [XLEN-1:0] w_div_lo;

  // Restoring divide step: shift remainder left, subtract divisor if it fits
  always_comb begin
    w_shift   = {r_hi, r_lo[XLEN-1]};
    w_qbit    = (w_shift >= {1'b0, r_m});
    w_diff    = w_shift[XLEN-1:0] - r_m;
    w_div_hi  = w_qbit ? w_diff : w_shift[XLEN-1:0];
    w_div_lo  = {r_lo[XLEN-2:0], w_qbit};
    o_hi_c    = r_mode_div ? w_div_hi : w_mul_hi;
    o_lo_c    = r_mode_div ? w_div_lo : w_mul_lo;
    w_load_lo = i_mode_div ? i_op_a : i_op_b;
    w_load_m  = i_mode_div ? i_op_b : i_op_a;
  end
`else
  logic w_unused_mode;

  // Multiply-only datapath
  always_comb begin
    o_hi_c        = w_mul_hi;
    o_lo_c        = w_mul_lo;
    w_load_lo     = i_op_b;
    w_load_m      = i_op_a;
    w_unused_mode = i_mode_div;
  end
`endif

  assign o_done_c = r_busy && (r_cnt == CW'(XLEN - 1));

  // Load on start, then iterate XLEN times; counter clears on the last step
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_m    <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
`ifdef ALU_MC_DIV_EN
      r_mode_div <= 1'b0;
`endif
    end else if (i_start) begin
      r_hi   <= '0;
      r_lo   <= w_load_lo;
      r_m    <= w_load_m;
      r_cnt  <= '0;
      r_busy <= 1'b1;
`ifdef ALU_MC_DIV_EN
      r_mode_div <= i_mode_div;
`endif
    end else if (r_busy) begin
      r_hi <= o_hi_c;
      r_lo <= o_lo_c;
      if (o_done_c) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle integer ALU: single-cycle ops, iterative MUL/MULHU and,
// with ALU_MC_DIV_EN defined, iterative DIV/DIVU/REM/REMU.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic     clk_i,
  input  logic     rst_n_i,
  alu_mc_if.slave  bus
);
  localparam int unsigned SHW = $clog2(XLEN);

  alu_state_e      r_state;
  alu_op_e         r_op;
  logic [XLEN-1:0] r_data;
  logic            r_ready;
  logic            r_valid;
  logic            r_zero;

  alu_op_e         w_op;
  logic [SHW-1:0]  w_shamt;
  logic [XLEN-1:0] w_sc_res;
  logic            w_in_mul;
  logic            w_in_div;
  logic            w_start;
  logic [XLEN-1:0] w_it_a;
  logic [XLEN-1:0] w_it_b;
  logic            w_it_done;
  logic [XLEN-1:0] w_it_hi;
  logic [XLEN-1:0] w_it_lo;
  logic [XLEN-1:0] w_mul_res;

  // Single-cycle datapath straight off the bus operands
  always_comb begin
    w_op     = alu_op_e'(bus.ALUCtrl_i);
    w_shamt  = bus.data2_i[SHW-1:0];
    w_sc_res = '0;
    case (w_op)
      OP_ADD:  w_sc_res = bus.data1_i + bus.data2_i;
      OP_SUB:  w_sc_res = bus.data1_i - bus.data2_i;
      OP_AND:  w_sc_res = bus.data1_i & bus.data2_i;
      OP_OR:   w_sc_res = bus.data1_i | bus.data2_i;
      OP_SLT:  w_sc_res = XLEN'($signed(bus.data1_i) < $signed(bus.data2_i));
      OP_SLTU: w_sc_res = XLEN'(bus.data1_i < bus.data2_i);
      OP_XOR:  w_sc_res = bus.data1_i ^ bus.data2_i;
      OP_SLL:  w_sc_res = bus.data1_i << w_shamt;
      OP_SRL:  w_sc_res = bus.data1_i >> w_shamt;
      OP_SRA:  w_sc_res = $signed(bus.data1_i) >>> w_shamt;
      default: w_sc_res = '0;
    endcase
  end

`ifdef ALU_MC_DIV_EN
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic            w_sgn_in;
  logic            w_sgn;
  logic            w_neg_a;
  logic            w_neg_b;
  logic [XLEN-1:0] w_quo;
  logic [XLEN-1:0] w_rem;
  logic [XLEN-1:0] w_div_res;

  // Divider operand magnitudes in; sign fix-up on the final iteration out
  always_comb begin
    w_in_div  = is_div_op(w_op);
    w_sgn_in  = (w_op == OP_DIV) || (w_op == OP_REM);
    w_it_a    = (w_in_div && w_sgn_in && bus.data1_i[XLEN-1]) ? -bus.data1_i : bus.data1_i;
    w_it_b    = (w_in_div && w_sgn_in && bus.data2_i[XLEN-1]) ? -bus.data2_i : bus.data2_i;
    w_sgn     = (r_op == OP_DIV) || (r_op == OP_REM);
    w_neg_a   = w_sgn && r_a[XLEN-1];
    w_neg_b   = w_sgn && r_b[XLEN-1];
    w_quo     = (r_b == '0) ? '1 : ((w_neg_a ^ w_neg_b) ? -w_it_lo : w_it_lo);
    w_rem     = w_neg_a ? -w_it_hi : w_it_hi;
    w_div_res = ((r_op == OP_DIV) || (r_op == OP_DIVU)) ? w_quo : w_rem;
  end

  // Raw operands kept for sign fix-up
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_a <= '0;
      r_b <= '0;
    end else if (w_start) begin
      r_a <= bus.data1_i;
      r_b <= bus.data2_i;
    end
  end
`else
  // No divider: iterator only ever sees raw multiply operands
  always_comb begin
    w_in_div = 1'b0;
    w_it_a   = bus.data1_i;
    w_it_b   = bus.data2_i;
  end
`endif

  assign w_in_mul  = is_mul_op(w_op);
  assign w_start   = (r_state == ST_IDLE) && bus.valid_i && (w_in_mul || w_in_div);
  assign w_mul_res = (r_op == OP_MULHU) ? w_it_hi : w_it_lo;

  alu_mc_iter #(.XLEN(XLEN)) u_iter (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .i_start    (w_start),
    .i_mode_div (w_in_div),
    .i_op_a     (w_it_a),
    .i_op_b     (w_it_b),
    .o_done_c   (w_it_done),
    .o_hi_c     (w_it_hi),
    .o_lo_c     (w_it_lo)
  );

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
      r_op    <= OP_ADD;
      r_data  <= '0;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.valid_i) begin
            r_op    <= w_op;
            r_ready <= 1'b0;
            if (w_in_mul) begin
              r_state <= ST_MUL;
            end else if (is_div_op(w_op)) begin
`ifdef ALU_MC_DIV_EN
              r_state <= ST_DIV;
`else
              r_state <= ST_DONE;
              r_valid <= 1'b1;
              r_data  <= '0;
              r_zero  <= 1'b1;
`endif
            end else begin
              r_state <= ST_DONE;
              r_valid <= 1'b1;
              r_data  <= w_sc_res;
              r_zero  <= (w_sc_res == '0);
            end
          end
        end
        ST_MUL: begin
          if (w_it_done) begin
            r_state <= ST_DONE;
            r_valid <= 1'b1;
            r_data  <= w_mul_res;
            r_zero  <= (w_mul_res == '0);
          end
        end
`ifdef ALU_MC_DIV_EN
        ST_DIV: begin
          if (w_it_done) begin
            r_state <= ST_DONE;
            r_valid <= 1'b1;
            r_data  <= w_div_res;
            r_zero  <= (w_div_res == '0);
          end
        end
`endif
        ST_DONE: begin
          if (bus.ready_i) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_zero  <= 1'b0;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready_o = r_ready;
  assign bus.valid_o = r_valid;
  assign bus.data_o  = r_data;
  assign bus.zero_o  = r_zero;

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc (XLEN=32); divide expectations follow ALU_MC_DIV_EN.
module tb_alu_mc;
  import alu_mc_pkg::*;

  localparam int unsigned XLEN = 32;
`ifdef ALU_MC_DIV_EN
  localparam int DIV_LAT = XLEN + 1;
`else
  localparam int DIV_LAT = 1;
`endif

  typedef struct {
    logic [31:0] data;
    int          lat;
    string       tag;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  alu_mc_if #(.XLEN(XLEN)) bus ();

  alu_mc #(.XLEN(XLEN)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Drive one op at a negedge; returns at the negedge after the accept edge
  task automatic issue(input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input string tag);
    exp_t e;
    check({tag, "_rdy"}, 64'(bus.ready_o), 64'd1);
    bus.valid_i   = 1'b1;
    bus.ALUCtrl_i = op;
    bus.data1_i   = a;
    bus.data2_i   = b;
    e.data = exp;
    e.lat  = lat;
    e.tag  = tag;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    bus.valid_i = 1'b0;
  endtask

  // Wait (bounded) for the result, compare against the scoreboard, handshake
  task automatic collect();
    int   lat;
    exp_t e;
    lat = 1;
    while (!bus.valid_o && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    e = sb_q.pop_front();
    check({e.tag, "_vld"},  64'(bus.valid_o), 64'd1);
    check({e.tag, "_data"}, 64'(bus.data_o), 64'(e.data));
    check({e.tag, "_zero"}, 64'(bus.zero_o), 64'(e.data == 32'd0));
    check({e.tag, "_lat"},  64'(lat), 64'(e.lat));
    check({e.tag, "_nrdy"}, 64'(bus.ready_o), 64'd0);
    bus.ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.ready_i = 1'b0;
    check({e.tag, "_clr"}, 64'(bus.valid_o), 64'd0);
  endtask

  task automatic run(input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input int lat, input string tag);
    issue(op, a, b, exp, lat, tag);
    collect();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.valid_i   = 1'b0;
    bus.ready_i   = 1'b0;
    bus.ALUCtrl_i = 4'd0;
    bus.data1_i   = '0;
    bus.data2_i   = '0;
    repeat (2) @(negedge clk);
    check("rst_rdy",  64'(bus.ready_o), 64'd1);
    check("rst_vld",  64'(bus.valid_o), 64'd0);
    check("rst_data", 64'(bus.data_o),  64'd0);
    check("rst_zero", 64'(bus.zero_o),  64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single-cycle ops
    run(OP_ADD,  32'hFFFF_FFFF, 32'd1,        32'h0,         1, "add_wrap");
    run(OP_SUB,  32'd5,         32'd7,        32'hFFFF_FFFE, 1, "sub");
    run(OP_AND,  32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1, "and");
    run(OP_OR,   32'hF000_0001, 32'h0000_0F00, 32'hF000_0F01, 1, "or");
    run(OP_SLT,  32'hFFFF_FFFF, 32'd1,        32'd1,         1, "slt");
    run(OP_SLTU, 32'hFFFF_FFFF, 32'd1,        32'd0,         1, "sltu");
    run(OP_XOR,  32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1, "xor");
    run(OP_SLL,  32'h0000_0001, 32'd33,       32'h0000_0002, 1, "sll33");
    run(OP_SRL,  32'h8000_0000, 32'd4,        32'h0800_0000, 1, "srl");
    run(OP_SRA,  32'h8000_0000, 32'd31,       32'hFFFF_FFFF, 1, "sra31");

    // Multiply
    run(OP_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, XLEN + 1, "mul_ff");
    run(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, XLEN + 1, "mulhu_ff");
    run(OP_MUL,   32'd1234,      32'd5678,      32'd7006652,   XLEN + 1, "mul_small");
    run(OP_MULHU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, XLEN + 1, "mulhu_16");

    // Divide family
`ifdef ALU_MC_DIV_EN
    run(OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, DIV_LAT, "div_m7_2");
    run(OP_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, DIV_LAT, "rem_m7_2");
    run(OP_DIVU, 32'd7,         32'd0,         32'hFFFF_FFFF, DIV_LAT, "divu_by0");
    run(OP_REM,  32'd7,         32'd0,         32'd7,         DIV_LAT, "rem_by0");
    run(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, DIV_LAT, "div_ovf");
    run(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         DIV_LAT, "rem_ovf");
    run(OP_DIV,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, DIV_LAT, "div_neg_by0");
    run(OP_REMU, 32'd100,       32'd7,         32'd2,         DIV_LAT, "remu");
    run(OP_DIVU, 32'hFFFF_FFFF, 32'd16,        32'h0FFF_FFFF, DIV_LAT, "divu");
`else
    run(OP_DIV,  32'd8,  32'd2, 32'd0, DIV_LAT, "div_off");
    run(OP_REMU, 32'd7,  32'd3, 32'd0, DIV_LAT, "remu_off");
`endif

    // Reset in the middle of a multiply
    bus.valid_i   = 1'b1;
    bus.ALUCtrl_i = OP_MUL;
    bus.data1_i   = 32'd3;
    bus.data2_i   = 32'd5;
    @(posedge clk);
    @(negedge clk);
    bus.valid_i = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_vld", 64'(bus.valid_o), 64'd0);
    check("midrst_rdy", 64'(bus.ready_o), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(OP_ADD, 32'd1, 32'd1, 32'd2, 1, "post_rst_add");
    repeat (XLEN + 4) @(negedge clk);
    check("post_rst_idle", 64'(bus.valid_o), 64'd0);

    // Backpressure: result held, new requests ignored until handshake
    issue(OP_ADD, 32'd10, 32'd20, 32'd30, 1, "bp");
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_data", 64'(bus.data_o),  64'd30);
      check("bp_hold_rdy",  64'(bus.ready_o), 64'd0);
      check("bp_hold_vld",  64'(bus.valid_o), 64'd1);
      bus.valid_i   = (i == 1 || i == 3);
      bus.ALUCtrl_i = OP_SUB;
      bus.data1_i   = 32'd100;
      bus.data2_i   = 32'd1;
      @(negedge clk);
    end
    bus.valid_i = 1'b0;
    collect();
    run(OP_OR, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1, "post_bp_or");

    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
